// File: rtl/gcd_method_responder_if.sv
// Purpose: call/return bundle between a caller and the GCD method responder.
// Ports  : gcd_a/gcd_b arguments, gcd_req call request (caller -> callee);
//          gcd_busy call-in-progress flag and gcd_return result (callee -> caller).
interface gcd_method_responder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic             gcd_req;
    logic             gcd_busy;
    logic [WIDTH-1:0] gcd_return;

    // Caller side
    modport master (
        output gcd_a,
        output gcd_b,
        output gcd_req,
        input  gcd_busy,
        input  gcd_return
    );

    // Callee side
    modport slave (
        input  gcd_a,
        input  gcd_b,
        input  gcd_req,
        output gcd_busy,
        output gcd_return
    );
endinterface

// File: rtl/gcd_method_responder.sv
// Purpose: callee for a req/busy/return method call; computes gcd(a,b) with binary (Stein) GCD.
// Latency: 2 busy cycles if either argument is 0, otherwise at most 4*WIDTH+4 busy cycles.
// Backpressure: none; a new call needs a fresh rising edge of gcd_req seen in IDLE.
// Ports  : clk, reset (sync, active-high), bus (slave modport: gcd_a, gcd_b, gcd_req in;
//          gcd_busy, gcd_return out).
module gcd_method_responder #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    gcd_method_responder_if.slave bus
);
    localparam int KW = $clog2(WIDTH) + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] STRIP2 = 3'd1;
    localparam logic [2:0] STRIPA = 3'd2;
    localparam logic [2:0] LOOP   = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             req_q;           // previous-cycle copy of gcd_req, for edge detect
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [KW-1:0]    k_q, k_d;        // count of common factors of two
    logic [WIDTH-1:0] ret_q, ret_d;
    logic             start;

    // A request held through reset is not a call yet; it starts in the
    // first cycle after reset releases, because req_q is cleared by reset.
    assign start = (state_q == IDLE) && bus.gcd_req && !req_q && !reset;

    assign bus.gcd_busy   = (state_q != IDLE) || start;
    assign bus.gcd_return = ret_q;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        k_d     = k_q;
        ret_d   = ret_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d = bus.gcd_a;
                    rb_d = bus.gcd_b;
                    k_d  = '0;
                    if (bus.gcd_a == '0 || bus.gcd_b == '0) begin
                        // gcd(x,0) = x; OR picks the nonzero one (or 0 for 0,0)
                        ra_d    = bus.gcd_a | bus.gcd_b;
                        state_d = FINISH;
                    end else begin
                        state_d = STRIP2;
                    end
                end
            end
            STRIP2: begin
                if (!ra_q[0] && !rb_q[0]) begin
                    ra_d = ra_q >> 1;
                    rb_d = rb_q >> 1;
                    k_d  = k_q + KW'(1);
                end else begin
                    state_d = STRIPA;
                end
            end
            STRIPA: begin
                if (!ra_q[0]) begin
                    ra_d = ra_q >> 1;
                end else begin
                    state_d = LOOP;
                end
            end
            LOOP: begin
                // ra stays odd here; rb is reduced until it reaches 0
                if (rb_q == '0) begin
                    state_d = FINISH;
                end else if (!rb_q[0]) begin
                    rb_d = rb_q >> 1;
                end else if (ra_q > rb_q) begin
                    ra_d = rb_q;
                    rb_d = ra_q;
                end else begin
                    rb_d = rb_q - ra_q;
                end
            end
            FINISH: begin
                // The result divides both arguments, so restoring 2^k cannot overflow
                ret_d   = ra_q << k_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            k_q     <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= bus.gcd_req;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            k_q     <= k_d;
            ret_q   <= ret_d;
        end
    end
endmodule

// File: doc/gcd_method_responder.md
Name: gcd_method_responder

Overview:
- Callee side of the method-call handshake: caller raises `gcd_req`, watches `gcd_busy`, and reads `gcd_return` once busy falls.
- The block latches two unsigned arguments at call start and computes their greatest common divisor with binary (Stein) GCD, one operation per cycle.
- It sits under a method-level test bench or a caller FSM as a reusable, bounded-latency arithmetic method.

Parameters:
- WIDTH, 32, bit width of both arguments and the result.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- gcd_a  input  WIDTH  first argument, sampled only at call start
- gcd_b  input  WIDTH  second argument, sampled only at call start
- gcd_req  input  1  call request; a call starts on a rising level seen in IDLE
- gcd_busy  output  1  high while a call is in progress
- gcd_return  output  WIDTH  result of the last completed call

Behaviour:
- Interface: one clock (`clk`); reset is synchronous and active-high (`reset`).
- Reset:
  - Forces state to IDLE and clears `req_d` (registered copy of `gcd_req`).
  - Clears `gcd_return` to 0 and all internal registers (`ra`, `rb`, `k`) to 0.
  - `gcd_busy` reads 0 while in IDLE with no start condition.
  - Reset mid-call aborts the call with no return update.
- Start condition: state==IDLE and `gcd_req`=1 and `req_d`=0.
  - `req_d` is 0 after reset, so a `gcd_req` held high through reset starts a call in the first post-reset cycle.
- `gcd_busy` = (state!=IDLE) OR start condition, combinational. It is high in the same cycle `req` first rises, with no gap until completion.
- States:
  - IDLE: on start, `ra`<=`gcd_a`, `rb`<=`gcd_b`, `k`<=0.
    - If `gcd_a`==0 or `gcd_b`==0, next state is FINISH with `ra`<=`gcd_a`|`gcd_b`.
    - Otherwise next state is STRIP2.
  - STRIP2: if `ra[0]`==0 and `rb[0]`==0, then `ra`>>=1, `rb`>>=1, `k`++ and stay; else go to STRIPA.
  - STRIPA: if `ra[0]`==0, `ra`>>=1 and stay; else go to LOOP.
  - LOOP, one action per cycle, in priority order:
    - `rb`==0 -> go to FINISH.
    - `rb[0]`==0 -> `rb`>>=1.
    - `ra`>`rb` -> swap `ra` and `rb`.
    - else `rb`<=`rb`-`ra`.
  - FINISH: `gcd_return`<=`ra`<<`k` (truncated to WIDTH, never overflows); next state IDLE.
- Completion timing: `gcd_busy` falls after the FINISH edge. The first cycle with busy=0 already shows the new `gcd_return`.
- Latency:
  - Zero operand: exactly 2 cycles of busy (start cycle plus FINISH).
  - General case: at most 4*WIDTH+4 busy cycles.
- Arithmetic:
  - Unsigned throughout; `k` is clog2(WIDTH)+1 bits.
  - Subtract is only performed when `ra`<=`rb`, so it never underflows.
- Arguments changing after the start cycle are ignored.
- `gcd_req` falling mid-call does not abort the call.
- `gcd_req` held high after completion does not restart. A new call requires `req` to go low for at least one cycle, then high.
- A rising `gcd_req` while not in IDLE is ignored. `req_d` still tracks `req`, so no call is queued.
- `gcd_return` holds its value between calls.

Test Plan:
- Basic call: reset for cycles 3..8, `gcd_a`=48, `gcd_b`=18, `req` high from cycle 100.
  - Required: busy=1 in the first req cycle, busy falls within 132 cycles, `gcd_return`=6.
- Zero operands:
  - (0,35) -> 35 with exactly 2 busy cycles.
  - Then req low, then (0,0) -> 0 with 2 busy cycles.
- Worst-case bound:
  - (1, 0xFFFFFFFF) -> 1; (0xFFFFFFFF, 0xFFFFFFFE) -> 1.
  - (0x80000000, 0x40000000) -> 0x40000000.
  - Each with busy ≤ 132 cycles.
- Handshake:
  - `req` held high for 1000 cycles after completion -> busy stays 0 and `gcd_return` unchanged.
  - Change args mid-call (from 48,18 to 7,5) -> result still 6.
- Reset mid-call: assert reset 3 cycles into a (48,18) call while `req` stays high.
  - Required: busy=0 and return=0 during reset.
  - After reset deasserts, a new call starts immediately and returns 6.
